// File: rtl/counterup_sched_pkg.sv
// ---------------------------------------------------------------------------
// counterup_sched_pkg
// Shared definitions for the time-shared round-robin counter bank:
//   DEF_NUM_CNT / DEF_CNT_W : default bank depth and counter width
//   sweep_state_t           : bank sweep-clear FSM states
//   rr_next()               : round-robin pointer advance rule
// ---------------------------------------------------------------------------
package counterup_sched_pkg;

    localparam int DEF_NUM_CNT = 8;
    localparam int DEF_CNT_W   = 16;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SWEEP = 1'b1
    } sweep_state_t;

    // Pointer moves to one past the granted index (wrapping at num);
    // it holds its value when nothing was granted.
    function automatic logic [31:0] rr_next(
        input logic [31:0] ptr,
        input logic [31:0] k,
        input logic        vld,
        input logic [31:0] num
    );
        logic [31:0] r;
        if (!vld) begin
            r = ptr;
        end else if (k == num - 32'd1) begin
            r = '0;
        end else begin
            r = k + 32'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/counterup_rr_arb.sv
// ---------------------------------------------------------------------------
// counterup_rr_arb
// Purely combinational round-robin picker: grants the first set bit of req
// at or above ptr, wrapping modulo NUM_CNT.
// Ports:
//   req     in  NUM_CNT         eligible requesters
//   ptr     in  $clog2(NUM_CNT) search start index
//   gnt     out NUM_CNT         one-hot grant (all zero when req is empty)
//   gnt_idx out $clog2(NUM_CNT) index of the granted requester
//   gnt_vld out 1               a grant was issued
// ---------------------------------------------------------------------------
module counterup_rr_arb
    import counterup_sched_pkg::*;
#(
    parameter int NUM_CNT = DEF_NUM_CNT
) (
    input  logic [NUM_CNT-1:0]         req,
    input  logic [$clog2(NUM_CNT)-1:0] ptr,
    output logic [NUM_CNT-1:0]         gnt,
    output logic [$clog2(NUM_CNT)-1:0] gnt_idx,
    output logic                       gnt_vld
);

    localparam int IDX_W = $clog2(NUM_CNT);

    logic             found;
    logic [IDX_W-1:0] sel_idx;
    // One spare bit so ptr+offset never overflows before the wrap subtract.
    logic [IDX_W:0]   pos;

    always_comb begin
        found   = 1'b0;
        sel_idx = '0;
        pos     = '0;
        for (int off = 0; off < NUM_CNT; off++) begin
            pos = {1'b0, ptr} + (IDX_W+1)'(off);
            if (pos >= (IDX_W+1)'(NUM_CNT)) begin
                pos = pos - (IDX_W+1)'(NUM_CNT);
            end
            if (!found && req[pos[IDX_W-1:0]]) begin
                found   = 1'b1;
                sel_idx = pos[IDX_W-1:0];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CNT; gi++) begin : g_gnt
            assign gnt[gi] = found && (sel_idx == IDX_W'(gi));
        end
    endgenerate

    assign gnt_idx = sel_idx;
    assign gnt_vld = found;

endmodule

// File: rtl/counterup16_rr_scheduler.sv
// ---------------------------------------------------------------------------
// counterup16_rr_scheduler
// NUM_CNT logical up-counters sharing one CNT_W-bit incrementer. A
// round-robin arbiter picks one requester per cycle; the granted counter
// takes the incremented value on the next edge. A sweep FSM clears the
// whole bank one entry per cycle after a clr_all pulse.
// Build option: define COUNTERUP_SAT_EN to make a granted counter at its
// maximum hold there instead of wrapping to zero (ovf_pulse fires either way).
// Ports:
//   clk       in  1              rising-edge clock
//   resetn    in  1              asynchronous active-low reset
//   inc_req   in  NUM_CNT        level increment requests
//   clr       in  NUM_CNT        per-counter synchronous clear
//   clr_all   in  1              start a bank sweep-clear (ignored while busy)
//   inc_gnt   out NUM_CNT        one-hot/zero grant, combinational
//   cnt_flat  out NUM_CNT*CNT_W  counter i at [i*CNT_W +: CNT_W]
//   ovf_pulse out NUM_CNT        1-cycle pulse: granted counter was at max
//   busy      out 1              sweep in progress
// ---------------------------------------------------------------------------
module counterup16_rr_scheduler
    import counterup_sched_pkg::*;
#(
    parameter int NUM_CNT = DEF_NUM_CNT,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [NUM_CNT-1:0]       inc_req,
    input  logic [NUM_CNT-1:0]       clr,
    input  logic                     clr_all,
    output logic [NUM_CNT-1:0]       inc_gnt,
    output logic [NUM_CNT*CNT_W-1:0] cnt_flat,
    output logic [NUM_CNT-1:0]       ovf_pulse,
    output logic                     busy
);

    localparam int               IDX_W    = $clog2(NUM_CNT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CNT - 1);

    sweep_state_t                  state_reg, state_next;
    logic [IDX_W-1:0]              idx_reg, idx_next;
    logic [IDX_W-1:0]              ptr_reg, ptr_next;
    logic [NUM_CNT-1:0][CNT_W-1:0] cnt_reg, cnt_next;
    logic [NUM_CNT-1:0]            ovf_reg, ovf_next;

    logic                          arb_en;
    logic                          sweep_clr;
    logic [NUM_CNT-1:0]            elig;
    logic [IDX_W-1:0]              gnt_idx;
    logic                          gnt_vld;
    logic [CNT_W-1:0]              sel_val;
    logic [CNT_W-1:0]              inc_val;
    logic                          sel_at_max;

    // ---------------- sweep FSM: state register ----------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg <= S_IDLE;
            idx_reg   <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
        end
    end

    // ---------------- sweep FSM: next state ----------------
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        case (state_reg)
            S_IDLE: begin
                if (clr_all) begin
                    state_next = S_SWEEP;
                    idx_next   = '0;
                end
            end
            S_SWEEP: begin
                if (idx_reg == LAST_IDX) begin
                    state_next = S_IDLE;
                    idx_next   = '0;
                end else begin
                    idx_next = idx_reg + 1'b1;
                end
            end
            default: begin
                state_next = S_IDLE;
                idx_next   = '0;
            end
        endcase
    end

    // ---------------- sweep FSM: outputs ----------------
    // Arbitration is shut off while sweeping, in the cycle that launches a
    // sweep, and while reset is asserted (grant is combinational).
    always_comb begin
        busy      = 1'b0;
        sweep_clr = 1'b0;
        arb_en    = 1'b0;
        case (state_reg)
            S_IDLE: begin
                arb_en = resetn && !clr_all;
            end
            S_SWEEP: begin
                busy      = 1'b1;
                sweep_clr = 1'b1;
            end
            default: begin
                arb_en = 1'b0;
            end
        endcase
    end

    // ---------------- arbitration ----------------
    // A requester being cleared this cycle is not eligible, so the clear wins.
    assign elig = arb_en ? (inc_req & ~clr) : '0;

    counterup_rr_arb #(
        .NUM_CNT (NUM_CNT)
    ) u_arb (
        .req     (elig),
        .ptr     (ptr_reg),
        .gnt     (inc_gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    assign ptr_next = IDX_W'(rr_next(32'(ptr_reg), 32'(gnt_idx), gnt_vld, 32'(NUM_CNT)));

    // ---------------- shared incrementer ----------------
    assign sel_val    = cnt_reg[gnt_idx];
    assign sel_at_max = &sel_val;

`ifdef COUNTERUP_SAT_EN
    assign inc_val = sel_at_max ? sel_val : sel_val + 1'b1;
`else
    assign inc_val = sel_val + 1'b1;
`endif

    // ---------------- counter bank next-state ----------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CNT; gi++) begin : g_bank
            logic wipe;
            assign wipe          = clr[gi] || (sweep_clr && (idx_reg == IDX_W'(gi)));
            assign cnt_next[gi]  = wipe ? '0 : (inc_gnt[gi] ? inc_val : cnt_reg[gi]);
            assign ovf_next[gi]  = inc_gnt[gi] && sel_at_max;
            assign cnt_flat[gi*CNT_W +: CNT_W] = cnt_reg[gi];
        end
    endgenerate

    // ---------------- bank, pointer and overflow registers ----------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_reg <= '0;
            ovf_reg <= '0;
            ptr_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
            ovf_reg <= ovf_next;
            ptr_reg <= ptr_next;
        end
    end

    assign ovf_pulse = ovf_reg;

endmodule

// File: tb/tb_counterup16_rr_scheduler.sv
// ---------------------------------------------------------------------------
// tb_counterup16_rr_scheduler
// Directed bench for counterup16_rr_scheduler (NUM_CNT=8, CNT_W=16) with a
// behavioural model of the bank (integer counters, round-robin pointer,
// sweep countdown) compared against the DUT every falling edge, plus
// hand-computed literal expectations. Honours COUNTERUP_SAT_EN.
// ---------------------------------------------------------------------------
module tb_counterup16_rr_scheduler;

    localparam int N    = 8;
    localparam int W    = 16;
    localparam int MAXV = 65535;
`ifdef COUNTERUP_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic           clk;
    logic           resetn;
    logic [N-1:0]   inc_req;
    logic [N-1:0]   clr;
    logic           clr_all;
    logic [N-1:0]   inc_gnt;
    logic [N*W-1:0] cnt_flat;
    logic [N-1:0]   ovf_pulse;
    logic           busy;

    int errors = 0;
    int checks = 0;

    counterup16_rr_scheduler #(.NUM_CNT(N), .CNT_W(W)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .inc_req   (inc_req),
        .clr       (clr),
        .clr_all   (clr_all),
        .inc_gnt   (inc_gnt),
        .cnt_flat  (cnt_flat),
        .ovf_pulse (ovf_pulse),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int           m_cnt [N];
    logic [N-1:0] m_ovf;
    int           m_ptr;
    bit           m_busy;
    int           m_sweep;

    // Expected grant index this cycle, -1 for none.
    function automatic int model_gnt();
        if (!resetn || m_busy || clr_all) return -1;
        for (int off = 0; off < N; off++) begin
            int k;
            k = (m_ptr + off) % N;
            if (inc_req[k] && !clr[k]) return k;
        end
        return -1;
    endfunction

    function automatic logic [N*W-1:0] model_flat();
        logic [N*W-1:0] f;
        f = '0;
        for (int i = 0; i < N; i++) f[i*W +: W] = W'(m_cnt[i]);
        return f;
    endfunction

    always @(posedge clk or negedge resetn) begin : model_upd
        automatic int           nc [N];
        automatic logic [N-1:0] no;
        automatic int           np;
        automatic bit           nb;
        automatic int           ns;
        automatic int           g;
        if (!resetn) begin
            for (int i = 0; i < N; i++) nc[i] = 0;
            no = '0; np = 0; nb = 1'b0; ns = 0;
        end else begin
            g  = model_gnt();
            nc = m_cnt; no = '0; np = m_ptr; nb = m_busy; ns = m_sweep;
            for (int i = 0; i < N; i++) if (clr[i]) nc[i] = 0;
            if (g >= 0) begin
                if (nc[g] == MAXV) begin
                    no[g] = 1'b1;
                    nc[g] = SAT ? MAXV : 0;
                end else begin
                    nc[g] = nc[g] + 1;
                end
                np = (g + 1) % N;
            end
            if (m_busy) begin
                nc[m_sweep] = 0;
                ns = m_sweep + 1;
                if (ns == N) begin nb = 1'b0; ns = 0; end
            end else if (clr_all) begin
                nb = 1'b1; ns = 0;
            end
        end
        m_cnt   <= nc;
        m_ovf   <= no;
        m_ptr   <= np;
        m_busy  <= nb;
        m_sweep <= ns;
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin : compare
        automatic int       g;
        automatic logic [N-1:0] eg;
        g  = model_gnt();
        eg = '0;
        if (g >= 0) eg[g] = 1'b1;
        chk("gnt_model", inc_gnt, eg);
        chk("gnt_onehot", ($countones(inc_gnt) <= 1), 1);
        chk("cnt_model", cnt_flat, model_flat());
        chk("ovf_model", ovf_pulse, m_ovf);
        chk("busy_model", busy, m_busy);
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0; inc_req = '0; clr = '0; clr_all = 1'b0;
        tick();
        resetn = 1'b1;
    endtask

    function automatic logic [W-1:0] cnt_of(input int i);
        return cnt_flat[i*W +: W];
    endfunction

    initial begin
        logic [N-1:0]   eg;
        logic [N*W-1:0] all7;

        resetn = 1'b0; inc_req = '0; clr = '0; clr_all = 1'b0;
        tick(); tick();
        resetn = 1'b1;

        // 1: make counter 0 nonzero, then async reset mid-cycle
        inc_req = 8'h01;
        repeat (3) tick();
        inc_req = 8'hFF;
        @(negedge clk);
        chk("t1_cnt0_pre", cnt_of(0), 16'd3);
        #2 resetn = 1'b0;
        #1;
        chk("t1_rst_cnt", cnt_flat, '0);
        chk("t1_rst_gnt", inc_gnt, '0);
        chk("t1_rst_busy", busy, 1'b0);
        tick();
        resetn = 1'b1;

        // 2: all requests held for 16 cycles; pointer restarts at 0
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            eg = 8'h01 << (i % 8);
            chk("t2_gnt_seq", inc_gnt, eg);
            tick();
        end
        inc_req = '0;
        @(negedge clk);
        for (int i = 0; i < N; i++) chk("t2_cnt_eq2", cnt_of(i), 16'd2);

        // 3: single requester, then wrap-around pick
        do_reset();
        inc_req = 8'h08;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_gnt3", inc_gnt, 8'h08);
            tick();
        end
        inc_req = 8'h0A;
        @(negedge clk);
        chk("t3_cnt3", cnt_of(3), 16'd5);
        chk("t3_gnt_wrap", inc_gnt, 8'h02);
        tick();
        inc_req = '0;

        // 4: drive counter 2 to max, then one more grant
        inc_req = 8'h04;
        repeat (MAXV) tick();
        @(negedge clk);
        chk("t4_cnt2_max", cnt_of(2), 16'hFFFF);
        chk("t4_ovf_pre", ovf_pulse, 8'h00);
        tick();
        inc_req = '0;
        @(negedge clk);
        chk("t4_cnt2_after", cnt_of(2), SAT ? 16'hFFFF : 16'h0000);
        chk("t4_ovf_pulse", ovf_pulse, 8'h04);
        tick();
        @(negedge clk);
        chk("t4_ovf_drop", ovf_pulse, 8'h00);

        // 5: clear masks a grant to the same counter, others proceed
        inc_req = 8'h20;
        tick(); tick();
        clr = 8'h20;
        @(negedge clk);
        chk("t5_cnt5_pre", cnt_of(5), 16'd2);
        chk("t5_gnt_masked", inc_gnt, 8'h00);
        tick();
        clr = '0; inc_req = '0;
        @(negedge clk);
        chk("t5_cnt5_clr", cnt_of(5), 16'd0);
        clr = 8'h20; inc_req = 8'h60;
        @(negedge clk);
        chk("t5_gnt_other", inc_gnt, 8'h40);
        tick();
        clr = '0; inc_req = '0;

        // 6: sweep-clear with all requests pending
        do_reset();
        inc_req = 8'hFF;
        repeat (56) tick();
        clr_all = 1'b1;
        all7 = '0;
        for (int i = 0; i < N; i++) all7[i*W +: W] = 16'd7;
        @(negedge clk);
        chk("t6_cnt7", cnt_flat, all7);
        chk("t6_gnt_launch", inc_gnt, 8'h00);
        tick();
        clr_all = 1'b0;
        for (int s = 0; s < N; s++) begin
            if (s == 3) clr_all = 1'b1;
            @(negedge clk);
            chk("t6_busy", busy, 1'b1);
            chk("t6_gnt_sweep", inc_gnt, 8'h00);
            tick();
            clr_all = 1'b0;
        end
        @(negedge clk);
        chk("t6_busy_done", busy, 1'b0);
        chk("t6_cnt_zero", cnt_flat, '0);
        chk("t6_gnt_resume", inc_gnt, 8'h01);
        tick();
        inc_req = '0;
        tick();
        clr_all = 1'b1;
        tick();
        clr_all = 1'b0;
        tick(); tick(); tick();
        @(negedge clk);
        chk("t6_busy_mid", busy, 1'b1);
        #2 resetn = 1'b0;
        #1;
        chk("t6_rst_busy", busy, 1'b0);
        chk("t6_rst_cnt", cnt_flat, '0);
        tick();
        resetn = 1'b1;
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
